// File: rtl/sm_result_collector.sv
// Smith-Waterman result collector: pairs lane scores with feeder IDs, removes the bias,
// filters on a threshold, tracks the best hit and buffers records for a valid/ready consumer.
module sm_result_collector #(
  parameter int SCORE_WIDTH = 12,
  parameter int ID_WIDTH    = 48,
  parameter int ZERO        = 2**(SCORE_WIDTH-1),
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vld0,
  input  logic                   vld1,
  input  logic [SCORE_WIDTH-1:0] result0,
  input  logic [SCORE_WIDTH-1:0] result1,
  input  logic [ID_WIDTH-1:0]    id0,
  input  logic [ID_WIDTH-1:0]    id1,
  output logic                   re0,
  output logic                   re1,
  input  logic [SCORE_WIDTH-1:0] threshold,
  input  logic                   clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ID_WIDTH-1:0]    out_id,
  output logic [SCORE_WIDTH-1:0] out_score,
  output logic                   best_valid,
  output logic [SCORE_WIDTH-1:0] best_score,
  output logic [ID_WIDTH-1:0]    best_id,
  output logic [CNT_WIDTH-1:0]   count,
  output logic [CNT_WIDTH-1:0]   dropped,
  output logic                   overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [SCORE_WIDTH-1:0] BIAS    = SCORE_WIDTH'(ZERO);
  localparam logic [CNT_WIDTH:0]     CNT_MAX = {1'b0, {CNT_WIDTH{1'b1}}};

  typedef struct packed {
    logic [ID_WIDTH-1:0]    id;
    logic [SCORE_WIDTH-1:0] score;
  } rec_t;

  logic vld0_q, vld1_q;
  logic cap0, cap1;
  logic [SCORE_WIDTH-1:0] score0, score1;
  rec_t hold0, hold1;
  logic hold0_vld, hold1_vld;
  logic pass0, pass1, drain0, drain1;
  logic push, pop, discard, space, fifo_full, lost;
  rec_t push_rec;
  rec_t mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic [CNT_WIDTH:0] count_sum, dropped_sum;
  logic cand_vld, cand_sel1;
  logic [SCORE_WIDTH-1:0] cand_score;
  logic [ID_WIDTH-1:0]    cand_id;

  // A capture is the rising edge of the level-valid from the scoring module.
  assign cap0   = vld0 & ~vld0_q;
  assign cap1   = vld1 & ~vld1_q;
  assign score0 = result0 + BIAS;
  assign score1 = result1 + BIAS;

  assign fifo_full = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign out_valid = (fifo_cnt != '0);
  assign pop       = out_valid & out_ready;
  assign space     = ~fifo_full | pop;

  // Discards never need FIFO space, so they drain even while the FIFO is full.
  assign pass0    = (hold0.score >= threshold);
  assign pass1    = (hold1.score >= threshold);
  assign drain0   = hold0_vld & (~pass0 | space);
  assign drain1   = hold1_vld & (~pass1 | space) & ~drain0;
  assign push     = (drain0 & pass0) | (drain1 & pass1);
  assign discard  = (drain0 & ~pass0) | (drain1 & ~pass1);
  assign push_rec = drain0 ? hold0 : hold1;
  assign lost     = (cap0 & hold0_vld) | (cap1 & hold1_vld);

  assign out_id    = out_valid ? mem[rd_ptr].id    : '0;
  assign out_score = out_valid ? mem[rd_ptr].score : '0;

  // Same-cycle tie goes to lane 0, so lane 1 is only chosen when strictly higher.
  assign cand_vld   = cap0 | cap1;
  assign cand_sel1  = cap1 & (~cap0 | (score1 > score0));
  assign cand_score = cand_sel1 ? score1 : score0;
  assign cand_id    = cand_sel1 ? id1 : id0;

  assign count_sum   = {1'b0, count} + (CNT_WIDTH+1)'(cap0) + (CNT_WIDTH+1)'(cap1);
  assign dropped_sum = {1'b0, dropped} + (CNT_WIDTH+1)'(discard);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld0_q    <= 1'b0;
      vld1_q    <= 1'b0;
      re0       <= 1'b0;
      re1       <= 1'b0;
      hold0     <= '0;
      hold1     <= '0;
      hold0_vld <= 1'b0;
      hold1_vld <= 1'b0;
    end else begin
      vld0_q <= vld0;
      vld1_q <= vld1;
      re0    <= cap0;
      re1    <= cap1;
      if (cap0 && !hold0_vld) begin
        hold0     <= '{id: id0, score: score0};
        hold0_vld <= 1'b1;
      end else if (drain0) begin
        hold0_vld <= 1'b0;
      end
      if (cap1 && !hold1_vld) begin
        hold1     <= '{id: id1, score: score1};
        hold1_vld <= 1'b1;
      end else if (drain1) begin
        hold1_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; out_valid and the output gating keep stale entries invisible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_rec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      dropped    <= '0;
      overflow   <= 1'b0;
      best_valid <= 1'b0;
      best_score <= '0;
      best_id    <= '0;
    end else if (clear) begin
      count      <= '0;
      dropped    <= '0;
      overflow   <= 1'b0;
      best_valid <= 1'b0;
      best_score <= '0;
      best_id    <= '0;
    end else begin
      count   <= (count_sum > CNT_MAX) ? CNT_MAX[CNT_WIDTH-1:0] : count_sum[CNT_WIDTH-1:0];
      dropped <= (dropped_sum > CNT_MAX) ? CNT_MAX[CNT_WIDTH-1:0] : dropped_sum[CNT_WIDTH-1:0];
      if (lost) overflow <= 1'b1;
      if (cand_vld && (!best_valid || cand_score > best_score)) begin
        best_valid <= 1'b1;
        best_score <= cand_score;
        best_id    <= cand_id;
      end
    end
  end

endmodule

// File: tb/tb_sm_result_collector.sv
// Self-checking bench for sm_result_collector: vector table plus scoreboard-checked output stream
// and hand-written sequences for overflow, held valid, clear priority and async reset.
module tb_sm_result_collector;

  localparam int SW = 12;
  localparam int IW = 48;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vld0 = 1'b0, vld1 = 1'b0;
  logic [SW-1:0] result0 = '0, result1 = '0;
  logic [IW-1:0] id0 = '0, id1 = '0;
  logic          re0, re1;
  logic [SW-1:0] threshold = '0;
  logic          clear = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [IW-1:0] out_id;
  logic [SW-1:0] out_score;
  logic          best_valid;
  logic [SW-1:0] best_score;
  logic [IW-1:0] best_id;
  logic [CW-1:0] count, dropped;
  logic          overflow;

  sm_result_collector #(.SCORE_WIDTH(SW), .ID_WIDTH(IW), .FIFO_DEPTH(8), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .vld0(vld0), .vld1(vld1), .result0(result0), .result1(result1),
    .id0(id0), .id1(id1), .re0(re0), .re1(re1), .threshold(threshold), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_score(out_score),
    .best_valid(best_valid), .best_score(best_score), .best_id(best_id),
    .count(count), .dropped(dropped), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [SW-1:0] score;
  } rec_t;

  typedef struct {
    bit            lane;
    int            raw;
    logic [IW-1:0] id;
    logic [SW-1:0] thr;
    bit            pass;
    logic [SW-1:0] score;
  } vec_t;

  rec_t sb[$];
  int   n_checks = 0;
  int   n_bad    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every record the consumer takes is compared with the oldest expected one.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_bad++;
        $display("FAIL unexpected_record: got id=%0h score=%0h with nothing expected", out_id, out_score);
      end else begin
        rec_t e;
        e = sb.pop_front();
        check("out_id", 64'(out_id), 64'(e.id));
        check("out_score", 64'(out_score), 64'(e.score));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit l0, input bit l1, input logic [SW-1:0] r0, input logic [SW-1:0] r1,
                       input logic [IW-1:0] i0, input logic [IW-1:0] i1);
    vld0 = l0; vld1 = l1; result0 = r0; result1 = r1; id0 = i0; id1 = i1;
    cyc();
    vld0 = 1'b0; vld1 = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < budget) begin
      cyc();
      n++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  vec_t vecs[8];
  int   exp_count, exp_dropped;
  logic [SW-1:0] exp_best;
  logic [IW-1:0] exp_best_id;
  bit   exp_bv;

  initial begin
    vecs[0] = '{0, -2038, 48'd7,             12'd0,    1'b1, 12'd10};
    vecs[1] = '{1, 5,     48'h123456789ABC,  12'd0,    1'b1, 12'd2053};
    vecs[2] = '{0, -2029, 48'd30,            12'd20,   1'b0, 12'd19};
    vecs[3] = '{0, -2028, 48'd31,            12'd20,   1'b1, 12'd20};
    vecs[4] = '{1, -2027, 48'd32,            12'd20,   1'b1, 12'd21};
    vecs[5] = '{1, -2048, 48'd40,            12'd0,    1'b1, 12'd0};
    vecs[6] = '{0, 2047,  48'hFFFFFFFFFFFF,  12'd4095, 1'b1, 12'd4095};
    vecs[7] = '{1, 2046,  48'd42,            12'd4095, 1'b0, 12'd4094};

    // Reset state
    repeat (2) cyc();
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_re", 64'({re0, re1}), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_best_valid", 64'(best_valid), 64'd0);
    check("rst_out_id", 64'(out_id), 64'd0);
    rst = 1'b0;
    cyc();

    // First transaction latency: re0 the cycle after capture, out_valid one cycle later
    vld0 = 1'b1; result0 = SW'(-2038); id0 = 48'd7;
    sb.push_back('{id: 48'd7, score: 12'd10});
    cyc();
    vld0 = 1'b0;
    @(negedge clk);
    check("lat_re0", 64'(re0), 64'd1);
    check("lat_out_valid_early", 64'(out_valid), 64'd0);
    check("lat_count", 64'(count), 64'd1);
    check("lat_best", 64'({best_score, best_id}), 64'({12'd10, 48'd7}));
    cyc();
    @(negedge clk);
    check("lat_re0_low", 64'(re0), 64'd0);
    check("lat_out_valid", 64'(out_valid), 64'd1);
    wait_empty(20);

    // Table-driven single-lane vectors
    cyc();
    do_clear();
    exp_count = 0; exp_dropped = 0; exp_bv = 0; exp_best = '0; exp_best_id = '0;
    foreach (vecs[k]) begin
      threshold = vecs[k].thr;
      if (vecs[k].pass) sb.push_back('{id: vecs[k].id, score: vecs[k].score});
      exp_count++;
      if (!vecs[k].pass) exp_dropped++;
      if (!exp_bv || vecs[k].score > exp_best) begin
        exp_bv = 1; exp_best = vecs[k].score; exp_best_id = vecs[k].id;
      end
      if (vecs[k].lane) pulse(0, 1, '0, SW'(vecs[k].raw), '0, vecs[k].id);
      else              pulse(1, 0, SW'(vecs[k].raw), '0, vecs[k].id, '0);
      repeat (3) cyc();
      check($sformatf("vec%0d_count", k), 64'(count), 64'(exp_count));
      check($sformatf("vec%0d_dropped", k), 64'(dropped), 64'(exp_dropped));
      check($sformatf("vec%0d_best", k), 64'({best_score, best_id}), 64'({exp_best, exp_best_id}));
    end
    wait_empty(20);
    threshold = '0;

    // Same-cycle capture on both lanes with equal scores
    do_clear();
    sb.push_back('{id: 48'd1, score: 12'd30});
    sb.push_back('{id: 48'd2, score: 12'd30});
    pulse(1, 1, SW'(-2018), SW'(-2018), 48'd1, 48'd2);
    @(negedge clk);
    check("dual_re", 64'({re0, re1}), 64'b11);
    check("dual_count", 64'(count), 64'd2);
    check("dual_best", 64'({best_score, best_id}), 64'({12'd30, 48'd1}));
    wait_empty(20);

    // Back-pressure: FIFO fills, both holding registers fill, then a lost result
    cyc();
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      bit l;
      l = (i < 10) ? bit'(i % 2) : 1'b0;
      if (i < 10) sb.push_back('{id: IW'(100 + i), score: SW'(i + 1)});
      if (i == 10) check("ovf_before", 64'(overflow), 64'd0);
      if (l) pulse(0, 1, '0, SW'(i + 1 - 2048), '0, IW'(100 + i));
      else   pulse(1, 0, SW'(i + 1 - 2048), '0, IW'(100 + i), '0);
      cyc();
    end
    @(negedge clk);
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_count", 64'(count), 64'd11);
    check("ovf_head_stable", 64'({out_valid, out_id}), 64'({1'b1, 48'd100}));
    cyc();
    out_ready = 1'b1;
    wait_empty(40);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Valid held high for five cycles yields one capture
    do_clear();
    begin
      int pulses = 0;
      vld0 = 1'b1; result0 = SW'(-2000); id0 = 48'd55;
      sb.push_back('{id: 48'd55, score: 12'd48});
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (re0) pulses++;
        if (c == 4) vld0 = 1'b0;
      end
      check("held_re0_pulses", 64'(pulses), 64'd1);
      check("held_count", 64'(count), 64'd1);
    end
    cyc();
    wait_empty(20);

    // Clear wins over a same-cycle capture; the record itself still flows
    clear = 1'b1;
    sb.push_back('{id: 48'd66, score: 12'd99});
    pulse(1, 0, SW'(99 - 2048), '0, 48'd66, '0);
    clear = 1'b0;
    @(negedge clk);
    check("clr_count", 64'(count), 64'd0);
    check("clr_best_valid", 64'(best_valid), 64'd0);
    wait_empty(20);

    // Asynchronous reset while a record is pending
    out_ready = 1'b0;
    pulse(1, 0, SW'(-1948), '0, 48'd77, '0);
    repeat (2) cyc();
    @(negedge clk);
    check("pre_rst_state", 64'({out_valid, best_valid}), 64'b11);
    #1 rst = 1'b1;
    #1;
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_best", 64'({best_valid, best_score}), 64'd0);
    check("async_count", 64'(count), 64'd0);
    check("async_out_id", 64'(out_id), 64'd0);
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    cyc();
    sb.push_back('{id: 48'd88, score: 12'd5});
    pulse(1, 0, SW'(5 - 2048), '0, 48'd88, '0);
    @(negedge clk);
    check("post_rst_count", 64'(count), 64'd1);
    wait_empty(20);

    repeat (2) cyc();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
